// File: rtl/mem_pkg.sv
// Shared types and constants for the stand-in data memory responder.
// Requests are captured whole into a packed struct so they can be replayed after the wait states.
package mem_pkg;

    localparam int WORD_W     = 32;
    localparam int BYTE_LANES = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    typedef struct packed {
        logic                  write;
        logic [WORD_W-1:0]     adr;
        logic [WORD_W-1:0]     data;
        logic [BYTE_LANES-1:0] byte_en;
    } mem_req_t;

    // A request is rejected if it is not word aligned or lies above the array
    function automatic logic req_err(input logic [WORD_W-1:0] adr, input int unsigned depth_log2);
        return (adr[1:0] != 2'b00) || ((adr >> (depth_log2 + 32'd2)) != {WORD_W{1'b0}});
    endfunction

endpackage

// File: rtl/data_mem_array.sv
// Single-port synchronous word RAM with byte-lane write enables and a registered read port.
module data_mem_array
    import mem_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  we,
    input  logic [BYTE_LANES-1:0] be,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [DATA_W-1:0]     wdata,
    output logic [DATA_W-1:0]     rdata
);

    logic [DATA_W-1:0] mem_q [0:(2**ADDR_W)-1];
    logic [DATA_W-1:0] rdata_q;

    // Byte-lane write into the array; contents are deliberately left unreset
    always_ff @(posedge clk) begin
        if (en && we) begin
            for (int i = 0; i < BYTE_LANES; i++) begin
                if (be[i]) begin
                    mem_q[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    // Registered read, held until the next read access
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= {DATA_W{1'b0}};
        end else if (en && !we) begin
            rdata_q <= mem_q[addr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/data_mem_responder.sv
// Data memory responder: accepts one request, waits WAIT_STATES cycles, accesses the
// array and holds the response until the consumer takes it.
module data_mem_responder
    import mem_pkg::*;
#(
    parameter int WORD_LENGTH = WORD_W,
    parameter int DEPTH_LOG2  = 10,
    parameter int WAIT_STATES = 2
) (
    input  logic                   inClk,
    input  logic                   inRst,
    input  logic                   inReqValid,
    output logic                   outReqReady,
    input  logic                   inReqWrite,
    input  logic [WORD_LENGTH-1:0] inReqAdr,
    input  logic [WORD_LENGTH-1:0] inReqData,
    input  logic [3:0]             inReqByteEn,
    output logic                   outRspValid,
    input  logic                   inRspReady,
    output logic [WORD_LENGTH-1:0] outRspData,
    output logic                   outRspErr
);

    localparam logic [3:0] WS_LOAD = 4'(WAIT_STATES);
    localparam logic       WS_ZERO = (WS_LOAD == 4'd0);

    state_e          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    mem_req_t        req_q, req_d;
    logic            req_ready_q, req_ready_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic            rsp_err_q, rsp_err_d;
    logic            rsp_zero_q, rsp_zero_d;

    mem_req_t        in_req_s, acc_req_s;
    logic            accept_s, access_s, acc_err_s;
    logic            ram_en_s, ram_we_s;
    logic [WORD_LENGTH-1:0] ram_rdata_s;

    assign in_req_s = {inReqWrite, inReqAdr, inReqData, inReqByteEn};
    assign accept_s = inReqValid && req_ready_q;

    // Decide whether the array is accessed this cycle and which request drives it
    always_comb begin
        access_s  = 1'b0;
        acc_req_s = req_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s && WS_ZERO) begin
                    access_s  = 1'b1;
                    acc_req_s = in_req_s;
                end else begin
                    access_s  = 1'b0;
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd1) begin
                    access_s = 1'b1;
                end else begin
                    access_s = 1'b0;
                end
            end
            default: begin
                access_s = 1'b0;
            end
        endcase
    end

    // Array controls; an erroneous request never touches the array
    always_comb begin
        acc_err_s = req_err(acc_req_s.adr, DEPTH_LOG2);
        ram_en_s  = access_s && !acc_err_s;
        ram_we_s  = ram_en_s && acc_req_s.write;
    end

    // Next-state and response bookkeeping
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        req_d       = req_q;
        rsp_valid_d = rsp_valid_q;
        rsp_err_d   = rsp_err_q;
        rsp_zero_d  = rsp_zero_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    req_d = in_req_s;
                    if (WS_ZERO) begin
                        state_d = ST_RESP;
                    end else begin
                        cnt_d   = WS_LOAD;
                        state_d = ST_WAIT;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = ST_RESP;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_RESP: begin
                if (inRspReady) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                rsp_valid_d = 1'b0;
            end
        endcase
        if (access_s) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = acc_err_s;
            rsp_zero_d  = acc_err_s || acc_req_s.write;
        end else begin
            rsp_err_d = rsp_err_d;
        end
        req_ready_d = (state_d == ST_IDLE);
    end

    // Control and response registers
    always_ff @(posedge inClk or negedge inRst) begin
        if (!inRst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            req_q       <= {$bits(mem_req_t){1'b0}};
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_zero_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            req_q       <= req_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_zero_q  <= rsp_zero_d;
        end
    end

    data_mem_array #(
        .DATA_W (WORD_LENGTH),
        .ADDR_W (DEPTH_LOG2)
    ) u_array (
        .clk   (inClk),
        .rst_n (inRst),
        .en    (ram_en_s),
        .we    (ram_we_s),
        .be    (acc_req_s.byte_en),
        .addr  (acc_req_s.adr[DEPTH_LOG2+1:2]),
        .wdata (acc_req_s.data),
        .rdata (ram_rdata_s)
    );

    // Writes and errors read back as zero; the RAM output register holds read data steady
    assign outRspData  = rsp_zero_q ? {WORD_LENGTH{1'b0}} : ram_rdata_s;
    assign outRspErr   = rsp_err_q;
    assign outRspValid = rsp_valid_q;
    assign outReqReady = req_ready_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: a WAIT_STATES=2 instance and a WAIT_STATES=0 instance
// sharing request wires, with the request valid steered by sel.
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sel;
    logic        req_valid, req_write, rsp_ready;
    logic [31:0] req_adr, req_data;
    logic [3:0]  req_be;

    logic        v2, ready2, valid2, err2;
    logic        v0, ready0, valid0, err0;
    logic [31:0] data2, data0;
    logic        o_ready, o_valid, o_err;
    logic [31:0] o_data;

    int cmp_cnt = 0;
    int err_cnt = 0;

    always #5 clk = ~clk;

    assign v2 = req_valid & ~sel;
    assign v0 = req_valid & sel;
    assign o_ready = sel ? ready0 : ready2;
    assign o_valid = sel ? valid0 : valid2;
    assign o_err   = sel ? err0   : err2;
    assign o_data  = sel ? data0  : data2;

    data_mem_responder #(.WORD_LENGTH(32), .DEPTH_LOG2(10), .WAIT_STATES(2)) dut (
        .inClk(clk), .inRst(rst_n),
        .inReqValid(v2), .outReqReady(ready2), .inReqWrite(req_write),
        .inReqAdr(req_adr), .inReqData(req_data), .inReqByteEn(req_be),
        .outRspValid(valid2), .inRspReady(rsp_ready),
        .outRspData(data2), .outRspErr(err2)
    );

    data_mem_responder #(.WORD_LENGTH(32), .DEPTH_LOG2(10), .WAIT_STATES(0)) dut0 (
        .inClk(clk), .inRst(rst_n),
        .inReqValid(v0), .outReqReady(ready0), .inReqWrite(req_write),
        .inReqAdr(req_adr), .inReqData(req_data), .inReqByteEn(req_be),
        .outRspValid(valid0), .inRspReady(rsp_ready),
        .outRspData(data0), .outRspErr(err0)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        cmp_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One full transaction: present, accept, measure latency, optionally stall, then consume
    task automatic xact(input logic s, input string tag, input logic wr,
                        input logic [31:0] adr, input logic [31:0] data, input logic [3:0] be,
                        input logic [31:0] exp_data, input logic exp_err,
                        input int exp_lat, input int hold);
        int lat;
        sel       = s;
        req_write = wr;
        req_adr   = adr;
        req_data  = data;
        req_be    = be;
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        #1;
        chk({tag, "/ready"}, {31'd0, o_ready}, 32'd1);
        tick();
        req_valid = 1'b0;
        lat = 1;
        while (o_valid !== 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
        chk({tag, "/lat"}, 32'(lat), 32'(exp_lat));
        chk({tag, "/data"}, o_data, exp_data);
        chk({tag, "/err"}, {31'd0, o_err}, {31'd0, exp_err});
        for (int i = 0; i < hold; i++) begin
            tick();
            chk({tag, "/hold_valid"}, {31'd0, o_valid}, 32'd1);
            chk({tag, "/hold_ready"}, {31'd0, o_ready}, 32'd0);
            chk({tag, "/hold_data"}, o_data, exp_data);
            chk({tag, "/hold_err"}, {31'd0, o_err}, {31'd0, exp_err});
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk({tag, "/done_valid"}, {31'd0, o_valid}, 32'd0);
        chk({tag, "/done_ready"}, {31'd0, o_ready}, 32'd1);
    endtask

    initial begin
        rst_n     = 1'b0;
        sel       = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_adr   = 32'd0;
        req_data  = 32'd0;
        req_be    = 4'd0;
        rsp_ready = 1'b0;
        tick();
        tick();
        chk("rst_ready", {31'd0, ready2}, 32'd1);
        chk("rst_valid", {31'd0, valid2}, 32'd0);
        chk("rst_data", data2, 32'd0);
        chk("rst_err", {31'd0, err2}, 32'd0);
        chk("rst0_ready", {31'd0, ready0}, 32'd1);
        rst_n = 1'b1;
        tick();

        // Basic write/read with two wait states
        xact(1'b0, "w10", 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0, 3, 0);
        xact(1'b0, "r10", 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0, 3, 0);
        // Byte lanes 0 and 2
        xact(1'b0, "w10be", 1'b1, 32'h10, 32'h11223344, 4'b0101, 32'h0, 1'b0, 3, 0);
        xact(1'b0, "r10be", 1'b0, 32'h10, 32'h0, 4'h0, 32'hDE22BE44, 1'b0, 3, 0);
        // Errors
        xact(1'b0, "r12mis", 1'b0, 32'h12, 32'h0, 4'h0, 32'h0, 1'b1, 3, 0);
        xact(1'b0, "w0", 1'b1, 32'h0, 32'hA5A50001, 4'hF, 32'h0, 1'b0, 3, 0);
        xact(1'b0, "w1000oor", 1'b1, 32'h1000, 32'hFFFFFFFF, 4'hF, 32'h0, 1'b1, 3, 0);
        xact(1'b0, "r0after", 1'b0, 32'h0, 32'h0, 4'h0, 32'hA5A50001, 1'b0, 3, 0);
        // Write with no lanes enabled
        xact(1'b0, "w0be0", 1'b1, 32'h0, 32'h00000000, 4'h0, 32'h0, 1'b0, 3, 0);
        xact(1'b0, "r0be0", 1'b0, 32'h0, 32'h0, 4'h0, 32'hA5A50001, 1'b0, 3, 0);
        // Backpressure for 5 cycles
        xact(1'b0, "bp", 1'b0, 32'h10, 32'h0, 4'h0, 32'hDE22BE44, 1'b0, 3, 5);

        // Zero wait states: setup, then back-to-back reads
        xact(1'b1, "z_w0", 1'b1, 32'h0, 32'h00001111, 4'hF, 32'h0, 1'b0, 1, 0);
        xact(1'b1, "z_w4", 1'b1, 32'h4, 32'h00002222, 4'hF, 32'h0, 1'b0, 1, 0);
        sel       = 1'b1;
        req_write = 1'b0;
        req_adr   = 32'h0;
        rsp_ready = 1'b1;
        req_valid = 1'b1;
        tick();
        chk("z_b2b1_valid", {31'd0, o_valid}, 32'd1);
        chk("z_b2b1_data", o_data, 32'h00001111);
        chk("z_b2b1_ready", {31'd0, o_ready}, 32'd0);
        req_adr = 32'h4;
        tick();
        chk("z_gap_valid", {31'd0, o_valid}, 32'd0);
        chk("z_gap_ready", {31'd0, o_ready}, 32'd1);
        tick();
        chk("z_b2b2_valid", {31'd0, o_valid}, 32'd1);
        chk("z_b2b2_data", o_data, 32'h00002222);
        req_valid = 1'b0;
        tick();
        chk("z_end_valid", {31'd0, o_valid}, 32'd0);
        rsp_ready = 1'b0;

        // Reset while a write is waiting
        xact(1'b0, "w20", 1'b1, 32'h20, 32'h13579BDF, 4'hF, 32'h0, 1'b0, 3, 0);
        sel       = 1'b0;
        req_write = 1'b1;
        req_adr   = 32'h20;
        req_data  = 32'hCAFEF00D;
        req_be    = 4'hF;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        tick();
        chk("mid_ready", {31'd0, ready2}, 32'd0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", {31'd0, valid2}, 32'd0);
        chk("mid_rst_ready", {31'd0, ready2}, 32'd1);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        xact(1'b0, "r20", 1'b0, 32'h20, 32'h0, 4'h0, 32'h13579BDF, 1'b0, 3, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Memory-side responder for the data requests issued by the memory access stage.
- Accepts one read or write request at a time over a valid/ready handshake.
- Inserts a configurable number of wait states, then accesses a word array with byte enables.
- Returns a response over a second valid/ready handshake that supports backpressure.
- Serves as the stand-in data memory for the pipeline until the cache exists.

Parameters:
- WORD_LENGTH, 32, data and address width in bits; equals the global `WORD_LENGTH.
- DEPTH_LOG2, 10, log2 of the number of words in the array (1024 words, 4 KB).
- WAIT_STATES, 2, extra cycles between request acceptance and the array access; range 0..15.

Ports:
- inClk  in  1  clock.
- inRst  in  1  reset, asynchronous, active-low.
- inReqValid  in  1  request valid.
- outReqReady  out  1  responder can accept a request.
- inReqWrite  in  1  1 = write, 0 = read.
- inReqAdr  in  WORD_LENGTH  byte address.
- inReqData  in  WORD_LENGTH  write data.
- inReqByteEn  in  4  write byte-lane enables; bit 3 = bits 31:24.
- outRspValid  out  1  response valid.
- inRspReady  in  1  consumer accepts the response.
- outRspData  out  WORD_LENGTH  read data; 0 for writes and errors.
- outRspErr  out  1  request was misaligned or out of range.

Behaviour:
- Clock and reset: one clock, inClk. Reset inRst is asynchronous and active-low. All state changes occur on the rising edge of inClk.
- Reset values: state IDLE, outReqReady=1, outRspValid=0, outRspData=0, outRspErr=0, wait counter 0. Array contents are not reset.
- State IDLE:
  - outReqReady=1.
  - On the edge where inReqValid and outReqReady are both 1, capture write, adr, data and byteEn.
  - Compute err = (adr[1:0]!=0) OR (adr[WORD_LENGTH-1:DEPTH_LOG2+2]!=0).
  - If WAIT_STATES==0: perform the access on this edge and go to RESP.
  - Otherwise load cnt=WAIT_STATES and go to WAIT.
- State WAIT:
  - outReqReady=0.
  - cnt decrements on each edge.
  - On the edge where cnt==1: perform the access and go to RESP.
- Access rules:
  - Word index is adr[DEPTH_LOG2+1:2].
  - Read: outRspData is loaded with the word at that index.
  - Write: only the enabled byte lanes are updated; outRspData=0.
  - If err: no array write and outRspData=0. outRspErr is loaded with err.
- State RESP:
  - outReqReady=0; outRspValid=1.
  - outRspData and outRspErr stay stable until the edge where inRspReady=1.
  - On that edge: outRspValid clears and the state goes to IDLE. The next request can be accepted one cycle later; there is no same-cycle turnaround.
- Latency: the response is valid WAIT_STATES+1 cycles after the acceptance edge, if the consumer holds inRspReady high.
- Write with inReqByteEn=0: the handshake and response proceed normally and the array is unchanged.
- inReqValid while not ready: ignored. The requester must hold the request stable until it is accepted.
- Reset mid-transaction:
  - Any transaction is dropped.
  - A write in WAIT is never committed.
  - A write already committed, i.e. in RESP, stays in the array.
  - outRspValid drops immediately because reset is asynchronous.
- Only one transaction is outstanding at a time, so there are no read/write hazards.

Decomposition:
- Package mem_pkg holds:
  - the state enum {IDLE, WAIT, RESP};
  - the BYTE_LANES=4 constant;
  - a packed request struct {write, adr, data, byteEn}.
- Sub-module data_mem_array: single-port synchronous RAM with byte-enable write and registered read. It is instantiated once.

Test Plan:
- Reset, then with WAIT_STATES=2: write 0xDEADBEEF to 0x10 with byteEn=4'hF; consume the response; read 0x10 -> outRspValid 3 cycles after acceptance, outRspData=0xDEADBEEF, outRspErr=0.
- Byte lanes: 0x10 holds 0xDEADBEEF; write 0x11223344 to 0x10 with byteEn=4'b0101; read 0x10 -> 0xDE22BE44.
- Errors:
  - Read 0x12 (misaligned) -> outRspErr=1, outRspData=0.
  - Write to 0x1000 (out of range for DEPTH_LOG2=10) -> outRspErr=1; a read of 0x0 afterwards is unchanged.
- Backpressure: hold inRspReady=0 for 5 cycles -> outRspValid, data and err are stable and outReqReady=0 throughout; release -> IDLE on the next edge.
- WAIT_STATES=0 build: back-to-back reads of 0x0 and 0x4 with inRspReady=1 -> each response 1 cycle after acceptance; the second request is accepted 2 cycles after the first.
- Reset mid-operation: accept a write of 0xCAFEF00D to 0x20; assert inRst=0 during WAIT -> outRspValid=0 and outReqReady=1 after reset; a read of 0x20 returns the prior value.
